// File: rtl/sram_rd_arbiter_if.sv
// AXI-lite read-channel bundle (address + data) shared by the IFU, LSU and SRAM
// sides of sram_rd_arbiter.
interface sram_rd_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/sram_rd_arbiter.sv
// Two-master (IFU=m0, LSU=m1) to one-SRAM read arbiter, one outstanding read.
// Define ARB_RR_EN to alternate grants on simultaneous requests instead of LSU-first.
module sram_rd_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    sram_rd_arbiter_if.slave  m0,
    sram_rd_arbiter_if.slave  m1,
    sram_rd_arbiter_if.master s
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    localparam logic [ADDR_W-1:0] NoAddr = '0;
    localparam logic [DATA_W-1:0] NoData = '0;

    state_e state_q, state_d;
    logic   gnt_q, gnt_d;
`ifdef ARB_RR_EN
    logic   last_q, last_d;
`endif

    logic [ADDR_W-1:0] sel_araddr;
    logic              sel_arvalid;
    logic              sel_rready;

    assign sel_araddr  = gnt_q ? m1.araddr  : m0.araddr;
    assign sel_arvalid = gnt_q ? m1.arvalid : m0.arvalid;
    assign sel_rready  = gnt_q ? m1.rready  : m0.rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 1'b0;
`ifdef ARB_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
`ifdef ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
`ifdef ARB_RR_EN
        last_d     = last_q;
`endif
        m0.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m0.rdata   = NoData;
        m0.rresp   = 2'b00;
        m1.arready = 1'b0;
        m1.rvalid  = 1'b0;
        m1.rdata   = NoData;
        m1.rresp   = 2'b00;
        s.araddr   = NoAddr;
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Arbitration takes this whole cycle; nothing is accepted here.
                if (m0.arvalid || m1.arvalid) begin
                    state_d = StAddr;
`ifdef ARB_RR_EN
                    if (m0.arvalid && m1.arvalid) gnt_d = ~last_q;
                    else                          gnt_d = m1.arvalid;
`else
                    gnt_d = m1.arvalid;
`endif
                end
            end
            StAddr: begin
                s.araddr   = sel_araddr;
                s.arvalid  = sel_arvalid;
                m0.arready = ~gnt_q & s.arready;
                m1.arready = gnt_q & s.arready;
                if (sel_arvalid && s.arready) state_d = StData;
            end
            StData: begin
                s.rready = sel_rready;
                if (gnt_q) begin
                    m1.rvalid = s.rvalid;
                    m1.rdata  = s.rdata;
                    m1.rresp  = s.rresp;
                end else begin
                    m0.rvalid = s.rvalid;
                    m0.rdata  = s.rdata;
                    m0.rresp  = s.rresp;
                end
                if (s.rvalid && sel_rready) begin
                    state_d = StIdle;
`ifdef ARB_RR_EN
                    last_d  = gnt_q;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/sram_rd_arbiter.md
Name: sram_rd_arbiter

Overview:
Two-master, one-slave AXI-lite read-channel arbiter that shares the single instruction/data SRAM between the IFU (master 0) and the LSU read path (master 1). It sits between both fetch/load units and the SRAM read port, and allows exactly one outstanding read at a time. The SRAM write channel is not arbitrated here; the LSU drives it directly as the sole writer.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read data width

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
m0_araddr  input  ADDR_W  IFU read address
m0_arvalid  input  1  IFU address valid
m0_arready  output  1  IFU address accepted
m0_rdata  output  DATA_W  IFU read data
m0_rresp  output  2  IFU read response
m0_rvalid  output  1  IFU data valid
m0_rready  input  1  IFU data ready
m1_araddr  input  ADDR_W  LSU read address
m1_arvalid  input  1  LSU address valid
m1_arready  output  1  LSU address accepted
m1_rdata  output  DATA_W  LSU read data
m1_rresp  output  2  LSU read response
m1_rvalid  output  1  LSU data valid
m1_rready  input  1  LSU data ready
s_araddr  output  ADDR_W  SRAM read address
s_arvalid  output  1  SRAM address valid
s_arready  input  1  SRAM address accepted
s_rdata  input  DATA_W  SRAM read data
s_rresp  input  2  SRAM read response
s_rvalid  input  1  SRAM data valid
s_rready  output  1  SRAM data ready

Behaviour:
- Registers: state (IDLE, ADDR, DATA); gnt (1 bit, 0=IFU, 1=LSU); last (1 bit, used only under ARB_RR_EN).
- Reset: state=IDLE, gnt=0, last=0. All valid/ready outputs are 0. s_araddr, m0_rdata and m1_rdata are 0 while in IDLE.
- IDLE:
  - All arready and rvalid outputs are 0. s_arvalid=0, s_rready=0.
  - If m1_arvalid=1: gnt<=1, state goes to ADDR. Else if m0_arvalid=1: gnt<=0, state goes to ADDR. Fixed priority, LSU first.
  - Arbitration costs exactly one cycle; no request is accepted in the IDLE cycle.
- ADDR:
  - s_araddr and s_arvalid are muxed combinationally from the granted master.
  - Granted master's arready = s_arready. Non-granted master's arready = 0.
  - On s_arvalid && s_arready, state goes to DATA.
  - If the granted master deasserts arvalid (protocol violation), the block stays in ADDR. Grant is never revoked mid-transaction.
- DATA:
  - Granted master receives s_rdata, s_rresp and s_rvalid. s_rready = granted master's rready.
  - Non-granted master sees rvalid=0 and rdata=0.
  - On s_rvalid && s_rready, state goes to IDLE and last<=gnt.
- Pass-through paths are purely combinational; there is no added data latency. Minimum turnaround is 3 cycles per transaction (IDLE, ADDR, DATA) when the SRAM responds in 0 cycles.
- Exactly one outstanding read. A second request, from either master, waits with arready=0 until the FSM returns to IDLE.
- Simultaneous requests in IDLE: LSU wins unless ARB_RR_EN is defined.
- A request that arrives in the same cycle the FSM returns to IDLE is arbitrated on the next cycle.
- rst asserted mid-transaction: the FSM returns to IDLE immediately and the in-flight response is discarded. The SRAM shares the same rst.
- rresp is forwarded unmodified; the arbiter never generates an error response.

Optional Feature:
ARB_RR_EN
- Defined: when both arvalid inputs are high in IDLE, grant the master != last. Single requests are granted as normal.
- Undefined: fixed LSU-first priority, and the last register is removed.

Test Plan:
- Single IFU read, addr 0x80000000, SRAM returns 0xDEADBEEF with 1-cycle latency -> m0_rdata=0xDEADBEEF and m0_rvalid=1 for exactly one handshake; m1_rvalid stays 0; FSM back in IDLE.
- Both masters assert arvalid in the same cycle (IFU 0x80000000, LSU 0x80001000) -> s_araddr=0x80001000 first, then 0x80000000; IFU arready stays 0 until the LSU handshake completes.
- Same stimulus as above, repeated 4 times with ARB_RR_EN defined -> grants alternate LSU, IFU, LSU, IFU.
- Granted master holds rready=0 for 3 cycles while s_rvalid=1 -> s_rready=0 for those 3 cycles; data is stable; completion occurs on the cycle rready rises.
- rst asserted while in DATA with s_rvalid pending -> all valid/ready outputs are 0 the same cycle; state=IDLE; a new IFU read afterwards completes normally.
- Back-to-back IFU reads at 0x0, 0x4 and 0x8 with a 0-latency SRAM -> each completes in 3 cycles; total 9 cycles; s_araddr sequence is 0x0, 0x4, 0x8.
